// File: rtl/dm_port_arbiter.sv
// Data-memory port arbiter: shares the single-port DM between the M-stage
// access and a DMA/debug requester. One transaction in flight at a time,
// sequenced IDLE -> ISSUE -> WAIT -> RESP. CPU has priority; a starvation
// counter forces a DMA grant after STARVE_MAX consecutive CPU grants.
module dm_port_arbiter #(
    parameter int unsigned AW         = 10,
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [3:0]    cpu_be,
    input  logic [31:0]   cpu_wdata,
    output logic [31:0]   cpu_rdata,
    output logic          cpu_stall,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [3:0]    dma_be,
    input  logic [31:0]   dma_wdata,
    output logic          dma_ack,
    output logic [31:0]   dma_rdata,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [3:0]    mem_be,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    output logic          busy
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StIssue = 2'd1;
    localparam logic [1:0] StWait  = 2'd2;
    localparam logic [1:0] StResp  = 2'd3;

    localparam logic OwnCpu = 1'b0;
    localparam logic OwnDma = 1'b1;

    localparam logic [2:0] LatLoad   = 3'(MEM_LAT - 1);
    localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

    logic [1:0]    state_q, state_d;
    logic [2:0]    cnt_q;
    logic          owner_q;
    logic [3:0]    starve_q;
    logic          mem_we_q;
    logic [AW-1:0] mem_addr_q;
    logic [3:0]    mem_be_q;
    logic [31:0]   mem_wdata_q;
    logic [31:0]   cpu_rdata_q;
    logic [31:0]   dma_rdata_q;

    logic          any_req;
    logic          dma_win;
    logic          grant;
    logic          capture;

    // Arbitration and next-state decode
    always_comb begin
        any_req = cpu_req | dma_req;
        // DMA wins when alone, or when it has been passed over STARVE_MAX times
        dma_win = dma_req & (~cpu_req | (starve_q == StarveMax));
        grant   = (state_q == StIdle) & any_req;
        capture = (state_q == StWait) & (cnt_q == 3'd0) & ~mem_we_q;
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (any_req) state_d = StIssue;
            StIssue: state_d = StWait;
            StWait:  if (cnt_q == 3'd0) state_d = StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Sequencer state, latency counter, owner and starvation counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= 3'd0;
            owner_q  <= OwnCpu;
            starve_q <= 4'd0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                owner_q <= dma_win ? OwnDma : OwnCpu;
                if (dma_win) begin
                    starve_q <= 4'd0;
                end else if (dma_req && (starve_q != StarveMax)) begin
                    starve_q <= starve_q + 4'd1;
                end
            end
            if (state_q == StIssue) begin
                cnt_q <= LatLoad;
            end else if ((state_q == StWait) && (cnt_q != 3'd0)) begin
                cnt_q <= cnt_q - 3'd1;
            end
        end
    end

    // Register the winner's command toward the memory
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= 4'd0;
            mem_wdata_q <= 32'd0;
        end else if (grant) begin
            mem_we_q    <= dma_win ? dma_we    : cpu_we;
            mem_addr_q  <= dma_win ? dma_addr  : cpu_addr;
            mem_be_q    <= dma_win ? dma_be    : cpu_be;
            mem_wdata_q <= dma_win ? dma_wdata : cpu_wdata;
        end
    end

    // Capture read data for the owner on the last wait cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_rdata_q <= 32'd0;
            dma_rdata_q <= 32'd0;
        end else if (capture) begin
            if (owner_q == OwnDma) begin
                dma_rdata_q <= mem_rdata;
            end else begin
                cpu_rdata_q <= mem_rdata;
            end
        end
    end

    assign mem_req   = (state_q == StIssue);
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_rdata = cpu_rdata_q;
    assign dma_rdata = dma_rdata_q;
    assign busy      = (state_q != StIdle);

    // Completion signalling is suppressed while reset is held
    assign cpu_stall = cpu_req & ~((state_q == StResp) & (owner_q == OwnCpu)) & ~rst;
    assign dma_ack   = (state_q == StResp) & (owner_q == OwnDma) & ~rst;

endmodule
